// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the RISC-V pipeline.
// Picks the bypass source for both ID/EX operands and raises stall on load-use,
// long-latency RAW and long-latency WAW hazards. It also tracks in-flight
// long-latency (divider/multiplier) destinations in a scoreboard.
module fwd_hazard_unit #(
    parameter int AW          = 5,
    parameter int FWD_STAGES  = 2,
    parameter int OUTSTANDING = 2,
    parameter int SEL_W       = $clog2(FWD_STAGES + 2),
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AW-1:0]            rs1,
    input  logic [AW-1:0]            rs2,
    input  logic                     rs1_used,
    input  logic                     rs2_used,
    input  logic [AW-1:0]            id_rd,
    input  logic                     id_regwrite,
    input  logic [FWD_STAGES*AW-1:0] stage_rd,
    input  logic [FWD_STAGES-1:0]    stage_regwrite,
    input  logic [FWD_STAGES-1:0]    stage_data_ready,
    input  logic                     lat_issue,
    input  logic [AW-1:0]            lat_issue_rd,
    input  logic                     lat_wb_valid,
    input  logic [AW-1:0]            lat_wb_rd,
    output logic [SEL_W-1:0]         forward_a,
    output logic [SEL_W-1:0]         forward_b,
    output logic                     stall,
    output logic                     lat_full,
    output logic [(2**AW)-1:0]       pending,
    output logic                     err_ovf,
    output logic                     err_wb,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int NUM_REGS = 2**AW;
    localparam int OCNT_W   = $clog2(OUTSTANDING + 1);

    logic [OCNT_W-1:0]   count;

    logic                hit_a, hit_b;
    logic                rdy_a, rdy_b;
    logic                wb_match_a, wb_match_b;
    logic                haz_a, haz_b, haz_waw;

    logic                wb_hit;
    logic [NUM_REGS-1:0] pend_after_clr;
    logic                issue_ok;
    logic                issue_bad;

    // Saturating increment so the stall counter sticks at its maximum
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Operand bypass select: scan oldest to youngest so the youngest hit wins
    always_comb begin
        hit_a     = 1'b0;
        hit_b     = 1'b0;
        rdy_a     = 1'b1;
        rdy_b     = 1'b1;
        forward_a = '0;
        forward_b = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stage_regwrite[k] && stage_rd[k*AW +: AW] == rs1 && rs1 != '0) begin
                hit_a     = 1'b1;
                rdy_a     = stage_data_ready[k];
                forward_a = SEL_W'(k + 1);
            end
            if (stage_regwrite[k] && stage_rd[k*AW +: AW] == rs2 && rs2 != '0) begin
                hit_b     = 1'b1;
                rdy_b     = stage_data_ready[k];
                forward_b = SEL_W'(k + 1);
            end
        end
        wb_match_a = lat_wb_valid && lat_wb_rd == rs1 && rs1 != '0;
        wb_match_b = lat_wb_valid && lat_wb_rd == rs2 && rs2 != '0;
        if (!hit_a && wb_match_a)
            forward_a = SEL_W'(FWD_STAGES + 1);
        if (!hit_b && wb_match_b)
            forward_b = SEL_W'(FWD_STAGES + 1);
    end

    // Hazard detection: load-use on a stage hit, LL RAW/WAW against the scoreboard
    always_comb begin
        haz_a   = rs1_used && ((hit_a && !rdy_a) ||
                               (!hit_a && rs1 != '0 && pending[rs1] && !wb_match_a));
        haz_b   = rs2_used && ((hit_b && !rdy_b) ||
                               (!hit_b && rs2 != '0 && pending[rs2] && !wb_match_b));
        haz_waw = id_regwrite && id_rd != '0 && pending[id_rd] &&
                  !(lat_wb_valid && lat_wb_rd == id_rd);
        stall    = haz_a || haz_b || haz_waw;
        lat_full = (count == OCNT_W'(OUTSTANDING));
    end

    // Scoreboard next-state: writeback clears first, issue is judged against the old count
    always_comb begin
        wb_hit         = lat_wb_valid && lat_wb_rd != '0 && pending[lat_wb_rd];
        pend_after_clr = pending;
        if (wb_hit)
            pend_after_clr[lat_wb_rd] = 1'b0;
        issue_ok  = lat_issue && lat_issue_rd != '0 &&
                    count < OCNT_W'(OUTSTANDING) && !pend_after_clr[lat_issue_rd];
        issue_bad = lat_issue && lat_issue_rd != '0 && !issue_ok;
    end

    // Scoreboard, outstanding count, sticky errors and stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            count     <= '0;
            err_ovf   <= 1'b0;
            err_wb    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pending <= pend_after_clr;
            if (issue_ok)
                pending[lat_issue_rd] <= 1'b1;
            count <= count + OCNT_W'(issue_ok) - OCNT_W'(wb_hit);
            if (issue_bad)
                err_ovf <= 1'b1;
            if (lat_wb_valid && !wb_hit)
                err_wb <= 1'b1;
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a behavioural model predicts each cycle's outputs,
// the prediction is queued when stimulus is applied and popped at the negedge.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int FS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1, rs2, id_rd, lat_issue_rd, lat_wb_rd;
    logic          rs1_used, rs2_used, id_regwrite, lat_issue, lat_wb_valid;
    logic [FS*AW-1:0] stage_rd;
    logic [FS-1:0] stage_regwrite, stage_data_ready;
    logic [1:0]    forward_a, forward_b;
    logic          stall, lat_full, err_ovf, err_wb;
    logic [31:0]   pending;
    logic [15:0]   stall_cnt;

    fwd_hazard_unit #(.AW(AW), .FWD_STAGES(FS), .OUTSTANDING(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .stage_rd(stage_rd), .stage_regwrite(stage_regwrite),
        .stage_data_ready(stage_data_ready),
        .lat_issue(lat_issue), .lat_issue_rd(lat_issue_rd),
        .lat_wb_valid(lat_wb_valid), .lat_wb_rd(lat_wb_rd),
        .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
        .lat_full(lat_full), .pending(pending), .err_ovf(err_ovf),
        .err_wb(err_wb), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fa, fb;
        logic        stall, full, eovf, ewb;
        logic [31:0] pend;
        logic [15:0] scnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_pend;
    int          m_cnt;
    logic        m_eovf, m_ewb;
    logic [15:0] m_scnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] srd(input int k);
        return stage_rd[k*AW +: AW];
    endfunction

    function automatic logic [1:0] m_sel(input logic [AW-1:0] rs);
        logic [1:0] s;
        s = 2'd0;
        if (rs != 0) begin
            for (int k = 0; k < FS; k++)
                if (s == 0 && stage_regwrite[k] && srd(k) == rs)
                    s = 2'(k + 1);
            if (s == 0 && lat_wb_valid && lat_wb_rd == rs)
                s = 2'd3;
        end
        return s;
    endfunction

    function automatic logic m_haz(input logic [AW-1:0] rs, input logic used);
        logic [1:0] s;
        s = m_sel(rs);
        if (!used || rs == 0) return 1'b0;
        if (s == 2'd1 || s == 2'd2) return !stage_data_ready[s - 1];
        return m_pend[rs] && !(lat_wb_valid && lat_wb_rd == rs);
    endfunction

    function automatic logic m_stall();
        logic waw;
        waw = id_regwrite && id_rd != 0 && m_pend[id_rd] &&
              !(lat_wb_valid && lat_wb_rd == id_rd);
        return m_haz(rs1, rs1_used) || m_haz(rs2, rs2_used) || waw;
    endfunction

    task automatic model_update();
        logic wbh;
        logic acc;
        logic [31:0] tmp;
        logic st;
        st = m_stall();
        if (!rst_n) begin
            m_pend = '0; m_cnt = 0; m_eovf = 0; m_ewb = 0; m_scnt = '0;
        end else begin
            wbh = lat_wb_valid && lat_wb_rd != 0 && m_pend[lat_wb_rd];
            tmp = m_pend;
            if (wbh) tmp[lat_wb_rd] = 1'b0;
            acc = 1'b0;
            if (lat_issue && lat_issue_rd != 0) begin
                if (m_cnt < 2 && !tmp[lat_issue_rd]) begin
                    acc = 1'b1;
                    tmp[lat_issue_rd] = 1'b1;
                end else begin
                    m_eovf = 1'b1;
                end
            end
            m_cnt = m_cnt + (acc ? 1 : 0) - (wbh ? 1 : 0);
            if (lat_wb_valid && !wbh) m_ewb = 1'b1;
            m_pend = tmp;
            if (st && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
        end
    endtask

    // One clock: predict, compare at negedge, advance model at posedge
    task automatic step();
        exp_t e, g;
        e.fa    = m_sel(rs1);
        e.fb    = m_sel(rs2);
        e.stall = m_stall();
        e.full  = (m_cnt == 2);
        e.eovf  = m_eovf;
        e.ewb   = m_ewb;
        e.pend  = m_pend;
        e.scnt  = m_scnt;
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk("forward_a", 32'(forward_a), 32'(g.fa));
        chk("forward_b", 32'(forward_b), 32'(g.fb));
        chk("stall", 32'(stall), 32'(g.stall));
        chk("lat_full", 32'(lat_full), 32'(g.full));
        chk("pending", pending, g.pend);
        chk("err_ovf", 32'(err_ovf), 32'(g.eovf));
        chk("err_wb", 32'(err_wb), 32'(g.ewb));
        chk("stall_cnt", 32'(stall_cnt), 32'(g.scnt));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
        id_rd = 0; id_regwrite = 0;
        stage_rd = '0; stage_regwrite = '0; stage_data_ready = '1;
        lat_issue = 0; lat_issue_rd = 0; lat_wb_valid = 0; lat_wb_rd = 0;
    endtask

    initial begin
        m_pend = '0; m_cnt = 0; m_eovf = 0; m_ewb = 0; m_scnt = '0;
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_update();
        step();
        rst_n = 1'b1;
        chk("rst_pending", pending, 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);

        // youngest stage wins
        stage_rd = {5'd5, 5'd5}; stage_regwrite = 2'b11; rs1 = 5; rs1_used = 1;
        #1;
        chk("young_wins_a", 32'(forward_a), 32'd1);
        chk("young_wins_stall", 32'(stall), 32'd0);
        step();
        stage_rd = {5'd5, 5'd6};
        step();
        rs1 = 0; stage_rd = '0;
        step();

        // load-use on stage 0
        idle();
        stage_rd = {5'd0, 5'd7}; stage_regwrite = 2'b01; stage_data_ready = 2'b10;
        rs2 = 7; rs2_used = 1;
        repeat (3) step();
        chk("load_use_cnt", 32'(stall_cnt), 32'd3);
        rs2_used = 0;
        #1;
        chk("unused_no_stall", 32'(stall), 32'd0);
        step();

        // LL RAW then same-cycle writeback bypass
        idle();
        lat_issue = 1; lat_issue_rd = 9;
        step();
        idle(); rs1 = 9; rs1_used = 1;
        step();
        lat_wb_valid = 1; lat_wb_rd = 9;
        #1;
        chk("ll_wb_fwd", 32'(forward_a), 32'd3);
        step();
        idle();
        step();
        chk("ll_cleared", 32'(pending[9]), 32'd0);

        // fill, overflow drop, drain
        lat_issue = 1; lat_issue_rd = 3; step();
        lat_issue_rd = 4; step();
        chk("full_flag", 32'(lat_full), 32'd1);
        lat_issue_rd = 6; step();
        chk("ovf_sticky", 32'(err_ovf), 32'd1);
        chk("ovf_not_recorded", 32'(pending[6]), 32'd0);
        idle(); lat_wb_valid = 1; lat_wb_rd = 3; step();
        lat_wb_rd = 4; step();

        // WAW and same-rd issue+wb
        idle(); lat_issue = 1; lat_issue_rd = 8; step();
        idle(); id_rd = 8; id_regwrite = 1; step();
        lat_issue = 1; lat_issue_rd = 8; lat_wb_valid = 1; lat_wb_rd = 8; step();
        chk("same_rd_kept", 32'(pending[8]), 32'd1);
        chk("same_rd_notfull", 32'(lat_full), 32'd0);
        idle(); lat_wb_valid = 1; lat_wb_rd = 8; step();

        // spurious writeback, x0 issue
        idle(); lat_wb_valid = 1; lat_wb_rd = 12; step();
        chk("wb_err", 32'(err_wb), 32'd1);
        chk("wb_err_pend", pending, 32'h0);
        idle(); lat_issue = 1; lat_issue_rd = 0; step();

        // random traffic over a small register window
        for (int i = 0; i < 300; i++) begin
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            rs1_used = 1'($urandom); rs2_used = 1'($urandom);
            id_rd = 5'($urandom_range(0, 7)); id_regwrite = 1'($urandom);
            stage_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            stage_regwrite = 2'($urandom); stage_data_ready = 2'($urandom);
            lat_issue = 1'($urandom); lat_issue_rd = 5'($urandom_range(0, 7));
            lat_wb_valid = 1'($urandom); lat_wb_rd = 5'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        // final reset
        idle(); rst_n = 1'b1; lat_issue = 1; lat_issue_rd = 10; step();
        idle(); rst_n = 1'b0; step();
        rst_n = 1'b1;
        chk("final_pending", pending, 32'h0);
        chk("final_errs", {30'd0, err_ovf, err_wb}, 32'h0);
        chk("final_cnt", 32'(stall_cnt), 32'h0);
        chk("final_full", 32'(lat_full), 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the RISC-V pipeline. Selects the bypass source for both ID/EX operands across FWD_STAGES younger pipeline stages plus a long-latency (LL) writeback port.
- Generates the pipeline stall for load-use, LL read-after-write and LL write-after-write hazards.
- Holds a sequential scoreboard of in-flight LL destinations (divider/multiplier), an outstanding-op counter, sticky error flags and a stall-cycle counter.

Parameters:
- AW, 5, register address width; NUM_REGS = 2**AW.
- FWD_STAGES, 2, number of forwarding stages; stage 0 is the youngest (EX/MEM).
- OUTSTANDING, 2, maximum number of LL ops in flight.
- SEL_W, clog2(FWD_STAGES+2), forward select width (derived).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- rs1, rs2  in  AW  ID/EX source registers.
- rs1_used, rs2_used  in  1  operand actually read.
- id_rd  in  AW  destination of the instruction in ID/EX.
- id_regwrite  in  1  that instruction writes id_rd.
- stage_rd  in  FWD_STAGES*AW  per-stage rd; stage k occupies slice k.
- stage_regwrite  in  FWD_STAGES  per-stage write enable.
- stage_data_ready  in  FWD_STAGES  result already available in that stage (0 = load still in flight).
- lat_issue  in  1  LL op issued this cycle.
- lat_issue_rd  in  AW  its destination.
- lat_wb_valid  in  1  LL result written back this cycle.
- lat_wb_rd  in  AW  its destination.
- forward_a, forward_b  out  SEL_W  0 = register file, k+1 = stage k, FWD_STAGES+1 = LL writeback.
- stall  out  1  hold IF/ID, bubble into EX.
- lat_full  out  1  outstanding count == OUTSTANDING.
- pending  out  NUM_REGS  scoreboard bitmap.
- err_ovf  out  1  sticky: illegal LL issue dropped.
- err_wb  out  1  sticky: LL writeback to a non-pending register.
- stall_cnt  out  CNT_W  cycles with stall=1, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge): pending=0, count=0, err_ovf=0, err_wb=0, stall_cnt=0. Reset mid-operation discards all in-flight LL tracking.
- forward_*, stall and lat_full are combinational from the inputs and the registered state, with zero latency.
- Register x0 is never forwarded, never stalls and never becomes pending.
- Operand select, per operand (shown for rs1):
  - Find the lowest k with stage_regwrite[k] && stage_rd[k]==rs1 && rs1!=0.
  - If found: forward_a = k+1. Older stage matches are ignored (youngest wins).
  - Else if lat_wb_valid && lat_wb_rd==rs1 && rs1!=0: forward_a = FWD_STAGES+1.
  - Else forward_a = 0.
  - forward_* are driven regardless of rs*_used.
- Stall is the OR of the following:
  - Load-use (per used operand): the selected stage k has stage_data_ready[k]==0.
  - LL RAW (per used operand): no stage hit, pending[rs]==1, and no same-cycle LL writeback to rs.
  - LL WAW: id_regwrite && id_rd!=0 && pending[id_rd] && !(lat_wb_valid && lat_wb_rd==id_rd).
- The pipeline deasserts stage_regwrite for an LL op once it is issued, so a register is never both pending and a stage hit.
- Scoreboard update at each clk edge, reset having priority:
  - WB clear: lat_wb_valid, lat_wb_rd!=0 and pending[lat_wb_rd] → clear the bit, count-1.
  - If lat_wb_valid targets a non-pending register (or x0) → ignored, err_wb<=1.
  - Issue: lat_issue with lat_issue_rd!=0 is accepted iff count < OUTSTANDING (evaluated before this cycle's WB) and the rd is not pending-after-clear. Accepted → set the bit, count+1.
  - Rejected issue → nothing recorded, err_ovf<=1.
  - lat_issue to x0 → ignored, no error.
  - Issue and WB to the same rd in the same cycle: clear then set. The bit ends at 1 and count is unchanged.
  - Issue and WB to different rds in the same cycle: both applied, count unchanged.
- count never exceeds OUTSTANDING and never underflows.
- stall_cnt increments each cycle stall=1 and saturates at 2**CNT_W-1.
- err_* clear only on reset.

Test Plan:
- Stage 0 rd=5 and stage 1 rd=5, both regwrite, rs1=5, rs2=0 → forward_a=1, forward_b=0, stall=0.
- stage_rd[0]=7, stage_data_ready[0]=0, rs2=7, rs2_used=1 → stall=1, stall_cnt increments each stalled cycle. With rs2_used=0 → stall=0.
- LL issue rd=9; next cycle rs1=9 used → stall=1. Assert lat_wb_valid rd=9 → same cycle forward_a=3, stall=0. Next cycle pending[9]=0.
- Issue rd=3 then rd=4 (OUTSTANDING=2) → lat_full=1. Third issue rd=6 → dropped, err_ovf=1, pending[6]=0.
- pending[8]=1, id_rd=8, id_regwrite=1 → stall=1. Same-cycle issue rd=8 with wb rd=8 → pending[8] stays 1, count unchanged.
- lat_wb_valid rd=12 with nothing pending → err_wb=1, count stays 0. Then rst_n=0 for one cycle → all state zero.
